// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: fetch-stage sequencer for the instruction memory.
// In LOAD it streams loader words into the memory write port; in RUN it owns
// the PC, presents it to the memory and captures the returned word into the
// IF/ID register, honouring stall and branch redirect.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_LOAD | boot-load: accept loader words, IF/ID held cleared, pc=RESET_PC
//   S_RUN  | fetch: advance/stall/redirect the PC, fill IF/ID each edge
module imem_fetch_ctrl #(
  parameter int unsigned ADDR_W   = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  output logic              load_ready,
  output logic [ADDR_W:0]   load_count,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic [31:0]       pc_out,
  input  logic [31:0]       instr_in,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_instr,
  output logic              if_valid
);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Memory depth expressed in the counter's own width (count reaches DEPTH).
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       if_pc_q, if_pc_d;
  logic [31:0]       if_instr_q, if_instr_d;
  logic              if_valid_q, if_valid_d;
  logic              xfer;

  // State register; an asserted reset forces LOAD.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: load_en level selects the mode for the next cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD: if (!load_en) state_d = S_RUN;
      S_RUN:  if (load_en)  state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  // Output logic: loader handshake and memory write port, gated off in reset.
  always_comb begin
    load_ready = 1'b0;
    if (reset && (state_q == S_LOAD) && (count_q < DEPTH)) begin
      load_ready = 1'b1;
    end
    xfer       = load_ready && load_valid;
    imem_we    = xfer;
    imem_waddr = count_q[ADDR_W-1:0];
    imem_wdata = load_data;
  end

  // Datapath next values: load counter, PC and IF/ID register.
  always_comb begin
    count_d    = count_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    case (state_q)
      S_LOAD: begin
        if (xfer) begin
          count_d = count_q + 1'b1;
        end
        // A word accepted on the exit cycle still counts; PC and IF/ID are
        // re-initialised so RUN starts cleanly from RESET_PC.
        if (!load_en) begin
          pc_d       = RESET_PC;
          if_pc_d    = 32'h0;
          if_instr_d = NOP;
          if_valid_d = 1'b0;
        end
      end
      S_RUN: begin
        if (load_en) begin
          // Mode change wins over any concurrent stall or redirect.
          count_d    = '0;
          pc_d       = RESET_PC;
          if_pc_d    = 32'h0;
          if_instr_d = NOP;
          if_valid_d = 1'b0;
        end else if (redirect_valid) begin
          // Redirect overrides stall; the in-flight fetch becomes a bubble.
          pc_d       = {redirect_pc[31:2], 2'b00};
          if_pc_d    = pc_q;
          if_instr_d = NOP;
          if_valid_d = 1'b0;
        end else if (!stall) begin
          pc_d       = pc_q + 32'd4;
          if_pc_d    = pc_q;
          if_instr_d = instr_in;
          if_valid_d = 1'b1;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Datapath registers with synchronous reset to the boot values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q    <= '0;
      pc_q       <= RESET_PC;
      if_pc_q    <= 32'h0;
      if_instr_q <= NOP;
      if_valid_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign load_count = count_q;
  assign pc_out     = pc_q;
  assign if_pc      = if_pc_q;
  assign if_instr   = if_instr_q;
  assign if_valid   = if_valid_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a small behavioural memory.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        load_en;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic [5:0]  load_count;
  logic        imem_we;
  logic [4:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] pc_out;
  logic [31:0] instr_in;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;

  logic [31:0] mem [32];
  int checks;
  int errors;

  imem_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .load_en        (load_en),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .load_ready     (load_ready),
    .load_count     (load_count),
    .imem_we        (imem_we),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata),
    .pc_out         (pc_out),
    .instr_in       (instr_in),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_valid       (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_we) mem[imem_waddr] <= imem_wdata;
  end
  assign instr_in = mem[pc_out[6:2]];

  function automatic logic [31:0] word_f(input int i);
    return 32'h002081B3 + (i * 32'h0010_0000);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    reset = 1'b0; load_en = 1'b1; load_valid = 1'b1; load_data = 32'hDEAD_BEEF;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

    // Reset for two edges; loader handshake must stay off throughout.
    tick();
    check("rst_we", {31'b0, imem_we}, 32'd0);
    check("rst_ready", {31'b0, load_ready}, 32'd0);
    tick();
    check("rst_count", {26'b0, load_count}, 32'd0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, NOP_W);
    check("rst_if_valid", {31'b0, if_valid}, 32'd0);

    // Stream 8 words.
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      load_valid = 1'b1; load_data = word_f(i);
      #1;
      check("ld8_we", {31'b0, imem_we}, 32'd1);
      check("ld8_waddr", {27'b0, imem_waddr}, i);
      check("ld8_wdata", imem_wdata, word_f(i));
      check("ld8_if_valid", {31'b0, if_valid}, 32'd0);
      tick();
    end
    load_valid = 1'b0;
    #1;
    check("ld8_count", {26'b0, load_count}, 32'd8);
    check("ld8_idle_we", {31'b0, imem_we}, 32'd0);

    // Restart load via reset and overflow with 34 words.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 34; i++) begin
      load_valid = 1'b1; load_data = word_f(i);
      #1;
      if (i < 32) begin
        check("ov_we", {31'b0, imem_we}, 32'd1);
        check("ov_waddr", {27'b0, imem_waddr}, i);
      end else begin
        check("ov_extra_we", {31'b0, imem_we}, 32'd0);
        check("ov_ready", {31'b0, load_ready}, 32'd0);
      end
      tick();
    end
    load_valid = 1'b0;
    check("ov_count", {26'b0, load_count}, 32'd32);
    check("ov_if_valid", {31'b0, if_valid}, 32'd0);

    // Enter RUN.
    load_en = 1'b0;
    tick();
    check("run0_pc", pc_out, 32'h0);
    check("run0_valid", {31'b0, if_valid}, 32'd0);
    check("run0_ready", {31'b0, load_ready}, 32'd0);
    tick();
    check("run1_pc", pc_out, 32'h4);
    check("run1_if_pc", if_pc, 32'h0);
    check("run1_instr", if_instr, word_f(0));
    check("run1_valid", {31'b0, if_valid}, 32'd1);
    tick();
    check("run2_pc", pc_out, 32'h8);
    check("run2_if_pc", if_pc, 32'h4);
    check("run2_instr", if_instr, word_f(1));

    // Stall 3 cycles at pc 8.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc_out, 32'h8);
      check("stall_if_pc", if_pc, 32'h4);
      check("stall_instr", if_instr, word_f(1));
    end
    stall = 1'b0;
    tick();
    check("resume_pc", pc_out, 32'hC);
    check("resume_if_pc", if_pc, 32'h8);
    check("resume_instr", if_instr, word_f(2));
    check("resume_valid", {31'b0, if_valid}, 32'd1);

    // Redirect while stalled; low bits forced to zero.
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_001E;
    tick();
    stall = 1'b0; redirect_valid = 1'b0;
    check("redir_pc", pc_out, 32'h1C);
    check("redir_valid", {31'b0, if_valid}, 32'd0);
    check("redir_instr", if_instr, NOP_W);
    check("redir_if_pc", if_pc, 32'hC);
    tick();
    check("post_redir_pc", pc_out, 32'h20);
    check("post_redir_if_pc", if_pc, 32'h1C);
    check("post_redir_instr", if_instr, word_f(7));
    check("post_redir_valid", {31'b0, if_valid}, 32'd1);
    tick();
    check("wrap_if_pc", if_pc, 32'h20);
    check("wrap_instr", if_instr, word_f(8));

    // load_en in RUN beats a concurrent redirect.
    load_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    tick();
    redirect_valid = 1'b0;
    check("reload_pc", pc_out, 32'h0);
    check("reload_count", {26'b0, load_count}, 32'd0);
    check("reload_ready", {31'b0, load_ready}, 32'd1);
    check("reload_valid", {31'b0, if_valid}, 32'd0);
    check("reload_instr", if_instr, NOP_W);

    // Back to RUN, advance to pc 0x10, then reset mid-run.
    load_en = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) tick();
    check("pre_rst_pc", pc_out, 32'h10);
    reset = 1'b0;
    tick();
    check("mid_rst_pc", pc_out, 32'h0);
    check("mid_rst_valid", {31'b0, if_valid}, 32'd0);
    check("mid_rst_count", {26'b0, load_count}, 32'd0);
    reset = 1'b1; load_en = 1'b1;
    #1;
    check("mid_rst_ready", {31'b0, load_ready}, 32'd1);

    // Re-load two new words and run from 0.
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_data = 32'hCAFE_0000 + i;
      tick();
    end
    load_valid = 1'b0; load_en = 1'b0;
    check("rl_count", {26'b0, load_count}, 32'd2);
    tick();
    check("rl_run_pc", pc_out, 32'h0);
    tick();
    check("rl_if_pc", if_pc, 32'h0);
    check("rl_instr", if_instr, 32'hCAFE_0000);
    tick();
    check("rl_instr1", if_instr, 32'hCAFE_0001);
    check("rl_pc2", pc_out, 32'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
